// File: rtl/game_sequencer.sv
// Boss-fight game flow: IDLE -> INTRO -> FIGHT (four spell phases) -> CLEAR/GAMEOVER,
// with lives, post-hit invulnerability and a start-key release interlock for restarts.
module game_sequencer #(
    parameter int PHASE_TICKS  = 1800,
    parameter int INTRO_TICKS  = 60,
    parameter int INVULN_TICKS = 120,
    parameter int P2_HP        = 375,
    parameter int P3_HP        = 250,
    parameter int P4_HP        = 125,
    parameter int LIVES        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] bosshp,
    input  logic       reimu_hit,
    output logic [2:0] state,
    output logic       enma1,
    output logic       enma2,
    output logic       enma3,
    output logic       enma4,
    output logic       boss_en,
    output logic       gameover,
    output logic [1:0] lives,
    output logic       invuln
);
    localparam int TW = $clog2(PHASE_TICKS + 1);
    localparam int IW = $clog2(INTRO_TICKS + 1);
    localparam int VW = $clog2(INVULN_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INTRO    = 3'd1,
        S_FIGHT    = 3'd2,
        S_CLEAR    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    state_t        st, st_n;
    logic [2:0]    phase, phase_n;
    logic [TW-1:0] ptmr, ptmr_n;
    logic [IW-1:0] icnt, icnt_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic [1:0]    lives_n;
    logic          released, released_n;
    logic          load_intro;
    logic [9:0]    next_thr;

    always_comb begin
        case (phase)
            3'd1:    next_thr = 10'(P2_HP);
            3'd2:    next_thr = 10'(P3_HP);
            default: next_thr = 10'(P4_HP);
        endcase
    end

    always_comb begin
        st_n       = st;
        phase_n    = phase;
        ptmr_n     = ptmr;
        icnt_n     = icnt;
        vcnt_n     = vcnt;
        lives_n    = lives;
        released_n = released;
        load_intro = 1'b0;

        if (tick && vcnt != '0)
            vcnt_n = vcnt - VW'(1);

        case (st)
            S_IDLE: begin
                if (tick && start)
                    load_intro = 1'b1;
            end
            S_INTRO: begin
                if (tick) begin
                    icnt_n = icnt + IW'(1);
                    if (int'(icnt) + 1 >= INTRO_TICKS - 1)
                        st_n = S_FIGHT;
                end
            end
            S_FIGHT: begin
                // lives reaching zero ends the fight on the next clk, regardless of tick
                if (lives == 2'd0) begin
                    st_n       = S_GAMEOVER;
                    released_n = 1'b0;
                end else if (tick && bosshp == 10'd0) begin
                    st_n       = S_CLEAR;
                    released_n = 1'b0;
                end else begin
                    if (tick) begin
                        if (phase != 3'd4) begin
                            if (bosshp <= next_thr || ptmr == TW'(PHASE_TICKS - 1)) begin
                                phase_n = phase + 3'd1;
                                ptmr_n  = '0;
                            end else begin
                                ptmr_n = ptmr + TW'(1);
                            end
                        end else if (ptmr != TW'(PHASE_TICKS - 1)) begin
                            ptmr_n = ptmr + TW'(1);
                        end
                    end
                    if (reimu_hit && vcnt == '0) begin
                        lives_n = lives - 2'd1;
                        vcnt_n  = VW'(INVULN_TICKS);
                    end
                end
            end
            S_CLEAR, S_GAMEOVER: begin
                // a held key must be released on some tick before it can restart
                if (tick) begin
                    if (start && released)
                        load_intro = 1'b1;
                    else if (!start)
                        released_n = 1'b1;
                end
            end
            default: st_n = S_IDLE;
        endcase

        if (load_intro) begin
            st_n    = S_INTRO;
            lives_n = 2'(LIVES);
            phase_n = 3'd1;
            ptmr_n  = '0;
            icnt_n  = '0;
            vcnt_n  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_IDLE;
            phase    <= 3'd1;
            ptmr     <= '0;
            icnt     <= '0;
            vcnt     <= '0;
            lives    <= 2'(LIVES);
            released <= 1'b1;
            enma1    <= 1'b0;
            enma2    <= 1'b0;
            enma3    <= 1'b0;
            enma4    <= 1'b0;
            boss_en  <= 1'b0;
            gameover <= 1'b0;
            invuln   <= 1'b0;
        end else begin
            st       <= st_n;
            phase    <= phase_n;
            ptmr     <= ptmr_n;
            icnt     <= icnt_n;
            vcnt     <= vcnt_n;
            lives    <= lives_n;
            released <= released_n;
            enma1    <= (st_n == S_FIGHT) && (phase_n == 3'd1);
            enma2    <= (st_n == S_FIGHT) && (phase_n == 3'd2);
            enma3    <= (st_n == S_FIGHT) && (phase_n == 3'd3);
            enma4    <= (st_n == S_FIGHT) && (phase_n == 3'd4);
            boss_en  <= (st_n == S_INTRO) || (st_n == S_FIGHT);
            gameover <= (st_n == S_GAMEOVER);
            invuln   <= (vcnt_n != '0);
        end
    end

    assign state = st;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start/intro, HP and timeout phases, hits,
// simultaneous clear+hit, async reset and the restart interlock.
module tb_game_sequencer;
    logic       clk, rst, tick, start, reimu_hit;
    logic [9:0] bosshp;
    logic [2:0] state;
    logic       enma1, enma2, enma3, enma4, boss_en, gameover, invuln;
    logic [1:0] lives;
    logic [3:0] enma;
    int         checks, failures;

    assign enma = {enma4, enma3, enma2, enma1};

    game_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .bosshp(bosshp),
        .reimu_hit(reimu_hit), .state(state), .enma1(enma1), .enma2(enma2),
        .enma3(enma3), .enma4(enma4), .boss_en(boss_en), .gameover(gameover),
        .lives(lives), .invuln(invuln)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // from IDLE/CLEAR/GAMEOVER: release, press, then run through the intro
    task automatic go_fight();
        start = 1'b0;
        ticks(1);
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        ticks(59);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (lives !== 2'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        checks++; if ({enma, boss_en, gameover, invuln} !== 7'b0) begin
            failures++; $display("FAIL reset_outs got=%b exp=0000000", {enma, boss_en, gameover, invuln}); end
        rst = 1'b0;
        start = 1'b0;
        ticks(3);
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
    endtask

    task automatic test_start();
        start = 1'b1;
        ticks(1);
        checks++; if (state !== 3'd1 || boss_en !== 1'b1) begin
            failures++; $display("FAIL start_intro got state=%0d boss_en=%b exp 1/1", state, boss_en); end
        checks++; if (enma !== 4'b0000) begin failures++; $display("FAIL intro_enma got=%b exp=0000", enma); end
        start = 1'b0;
        ticks(58);
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL intro_len got=%0d exp=1", state); end
        ticks(1);
        checks++; if (state !== 3'd2 || enma !== 4'b0001) begin
            failures++; $display("FAIL fight_entry got state=%0d enma=%b exp 2/0001", state, enma); end
        checks++; if (boss_en !== 1'b1) begin failures++; $display("FAIL fight_boss_en got=%b exp=1", boss_en); end
    endtask

    task automatic test_hp_phases();
        bosshp = 10'd375;
        ticks(1);
        checks++; if (enma !== 4'b0010) begin failures++; $display("FAIL hp_p2 got=%b exp=0010", enma); end
        bosshp = 10'd124;
        ticks(1);
        checks++; if (enma !== 4'b0100) begin failures++; $display("FAIL hp_p3 got=%b exp=0100", enma); end
        ticks(1);
        checks++; if (enma !== 4'b1000) begin failures++; $display("FAIL hp_p4 got=%b exp=1000", enma); end
        ticks(1);
        checks++; if (enma !== 4'b1000) begin failures++; $display("FAIL hp_p4_hold got=%b exp=1000", enma); end
        bosshp = 10'd0;
        ticks(1);
        checks++; if (state !== 3'd3 || enma !== 4'b0000 || boss_en !== 1'b0) begin
            failures++; $display("FAIL clear got state=%0d enma=%b boss_en=%b exp 3/0000/0", state, enma, boss_en); end
    endtask

    task automatic test_timeout();
        bosshp = 10'd500;
        go_fight();
        checks++; if (state !== 3'd2 || enma !== 4'b0001) begin
            failures++; $display("FAIL to_entry got state=%0d enma=%b exp 2/0001", state, enma); end
        ticks(1799);
        checks++; if (enma !== 4'b0001) begin failures++; $display("FAIL to_early got=%b exp=0001", enma); end
        ticks(1);
        checks++; if (enma !== 4'b0010) begin failures++; $display("FAIL to_p2 got=%b exp=0010", enma); end
        ticks(1800);
        checks++; if (enma !== 4'b0100) begin failures++; $display("FAIL to_p3 got=%b exp=0100", enma); end
        ticks(1800);
        checks++; if (enma !== 4'b1000) begin failures++; $display("FAIL to_p4 got=%b exp=1000", enma); end
        ticks(5000);
        checks++; if (state !== 3'd2 || enma !== 4'b1000) begin
            failures++; $display("FAIL to_p4_sat got state=%0d enma=%b exp 2/1000", state, enma); end
        bosshp = 10'd0;
        ticks(1);
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL to_clear got=%0d exp=3", state); end
    endtask

    task automatic test_hits();
        bosshp = 10'd500;
        go_fight();
        checks++; if (lives !== 2'd3 || invuln !== 1'b0) begin
            failures++; $display("FAIL hit_pre got lives=%0d invuln=%b exp 3/0", lives, invuln); end
        reimu_hit = 1'b1; step(); reimu_hit = 1'b0;
        checks++; if (lives !== 2'd2 || invuln !== 1'b1) begin
            failures++; $display("FAIL hit1 got lives=%0d invuln=%b exp 2/1", lives, invuln); end
        ticks(119);
        checks++; if (invuln !== 1'b1) begin failures++; $display("FAIL invuln_hold got=%b exp=1", invuln); end
        reimu_hit = 1'b1; step(); reimu_hit = 1'b0;
        checks++; if (lives !== 2'd2) begin failures++; $display("FAIL hit_ignored got=%0d exp=2", lives); end
        ticks(1);
        checks++; if (invuln !== 1'b0) begin failures++; $display("FAIL invuln_end got=%b exp=0", invuln); end
        reimu_hit = 1'b1; step(); reimu_hit = 1'b0;
        checks++; if (lives !== 2'd1) begin failures++; $display("FAIL hit2 got=%0d exp=1", lives); end
        ticks(120);
        reimu_hit = 1'b1; step(); reimu_hit = 1'b0;
        checks++; if (lives !== 2'd0 || state !== 3'd2 || gameover !== 1'b0) begin
            failures++; $display("FAIL hit3 got lives=%0d state=%0d go=%b exp 0/2/0", lives, state, gameover); end
        step();
        checks++; if (state !== 3'd4 || gameover !== 1'b1) begin
            failures++; $display("FAIL gameover got state=%0d go=%b exp 4/1", state, gameover); end
        checks++; if (enma !== 4'b0000 || boss_en !== 1'b0) begin
            failures++; $display("FAIL go_outs got enma=%b boss_en=%b exp 0000/0", enma, boss_en); end
    endtask

    task automatic test_simultaneous();
        bosshp = 10'd500;
        go_fight();
        checks++; if (state !== 3'd2 || lives !== 2'd3 || gameover !== 1'b0) begin
            failures++; $display("FAIL restart_go got state=%0d lives=%0d go=%b exp 2/3/0", state, lives, gameover); end
        bosshp = 10'd0;
        reimu_hit = 1'b1;
        ticks(1);
        reimu_hit = 1'b0;
        checks++; if (state !== 3'd3 || lives !== 2'd3 || invuln !== 1'b0) begin
            failures++; $display("FAIL simul got state=%0d lives=%0d invuln=%b exp 3/3/0", state, lives, invuln); end
    endtask

    task automatic test_reset_restart();
        bosshp = 10'd500;
        go_fight();
        bosshp = 10'd250;
        ticks(2);
        checks++; if (enma !== 4'b0100) begin failures++; $display("FAIL rr_p3 got=%b exp=0100", enma); end
        reimu_hit = 1'b1; step(); reimu_hit = 1'b0;
        checks++; if (lives !== 2'd2 || invuln !== 1'b1) begin
            failures++; $display("FAIL rr_hit got lives=%0d invuln=%b exp 2/1", lives, invuln); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || lives !== 2'd3) begin
            failures++; $display("FAIL async_rst got state=%0d lives=%0d exp 0/3", state, lives); end
        checks++; if ({enma, boss_en, gameover, invuln} !== 7'b0) begin
            failures++; $display("FAIL async_outs got=%b exp=0000000", {enma, boss_en, gameover, invuln}); end
        step();
        rst = 1'b0;
        bosshp = 10'd500;
        start = 1'b1;
        ticks(1);
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL rst_start got=%0d exp=1", state); end
        ticks(59);
        bosshp = 10'd0;
        ticks(1);
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL rr_clear got=%0d exp=3", state); end
        ticks(3);
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL held_key got=%0d exp=3", state); end
        start = 1'b0;
        ticks(1);
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL release got=%0d exp=3", state); end
        start = 1'b1;
        ticks(1);
        checks++; if (state !== 3'd1 || lives !== 2'd3 || boss_en !== 1'b1) begin
            failures++; $display("FAIL repress got state=%0d lives=%0d boss_en=%b exp 1/3/1", state, lives, boss_en); end
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        tick = 1'b0;
        start = 1'b0;
        reimu_hit = 1'b0;
        bosshp = 10'd500;
        test_reset();
        test_start();
        test_hp_phases();
        test_timeout();
        test_hits();
        test_simultaneous();
        test_reset_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
